// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S slave receiver.
package i2s_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} rx_state_t;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchroniser for an asynchronous input, with optional rising-edge pulse.
module i2s_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev;
            always_ff @(posedge clk) begin
                if (rst) prev <= 1'b0;
                else     prev <= q;
            end
            assign rise = q & ~prev;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: resynchronises SCK/WS/SD, deserialises MSB-first
// left/right words and holds each stereo pair in a valid/ready register.
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  lmmi_clk_i,
    input  logic                  reset_i,
    input  logic                  conf_en_i,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i,
    input  logic                  sample_ready_i,
    output logic [DATA_WIDTH-1:0] left_dat_o,
    output logic [DATA_WIDTH-1:0] right_dat_o,
    output logic                  sample_valid_o,
    output logic                  overrun_o,
    output logic                  short_slot_o,
    output logic                  locked_o
);

    localparam int CW = cnt_width(DATA_WIDTH);

    logic sck_s, sck_rise, ws_s, ws_rise, sd_s, sd_rise;
    logic unused_ok;

    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sck (
        .clk(lmmi_clk_i), .rst(reset_i), .d(i2s_sck_i), .q(sck_s), .rise(sck_rise));
    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_ws (
        .clk(lmmi_clk_i), .rst(reset_i), .d(i2s_ws_i), .q(ws_s), .rise(ws_rise));
    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sd (
        .clk(lmmi_clk_i), .rst(reset_i), .d(i2s_sd_i), .q(sd_s), .rise(sd_rise));

    assign unused_ok = ^{sck_s, ws_rise, sd_rise};

    rx_state_t             state;
    logic                  ws_last;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] shreg, word_nx, left_hold;
    logic                  slot_short;

    // Word as it stands once the current bit is stored; excess bits fall away.
    always_comb begin
        word_nx = shreg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cnt == CW'(DATA_WIDTH - 1 - i)) word_nx[i] = sd_s;
        end
        cnt_nx     = (cnt < CW'(DATA_WIDTH)) ? cnt + CW'(1) : cnt;
        slot_short = (cnt_nx < CW'(DATA_WIDTH));
    end

    always_ff @(posedge lmmi_clk_i) begin
        if (reset_i) begin
            state          <= IDLE;
            ws_last        <= I2S_LEFT;
            cnt            <= '0;
            shreg          <= '0;
            left_hold      <= '0;
            left_dat_o     <= '0;
            right_dat_o    <= '0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
            short_slot_o   <= 1'b0;
            locked_o       <= 1'b0;
        end else begin
            overrun_o    <= 1'b0;
            short_slot_o <= 1'b0;
            if (sample_valid_o && sample_ready_i) sample_valid_o <= 1'b0;

            if (!conf_en_i) begin
                state          <= IDLE;
                locked_o       <= 1'b0;
                sample_valid_o <= 1'b0;
                shreg          <= '0;
                cnt            <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SYNC;
                        shreg <= '0;
                        cnt   <= '0;
                    end
                    SYNC: if (sck_rise) begin
                        ws_last <= ws_s;
                        if (ws_last == I2S_RIGHT && ws_s == I2S_LEFT) begin
                            state    <= LEFT;
                            locked_o <= 1'b1;
                        end
                    end
                    LEFT, RIGHT: if (sck_rise) begin
                        ws_last <= ws_s;
                        if (ws_s != ws_last) begin
                            // The bit on the WS-change rise still belongs to the closing slot.
                            shreg        <= '0;
                            cnt          <= '0;
                            short_slot_o <= slot_short;
                            if (state == LEFT) begin
                                left_hold <= word_nx;
                                state     <= RIGHT;
                            end else begin
                                left_dat_o     <= left_hold;
                                right_dat_o    <= word_nx;
                                sample_valid_o <= 1'b1;
                                overrun_o      <= sample_valid_o && !sample_ready_i;
                                state          <= LEFT;
                            end
                        end else begin
                            shreg <= word_nx;
                            cnt   <= cnt_nx;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Self-checking bench for i2s_slave_rx: bit-level I2S master model, table vectors,
// random frames against a slot-level reference model, and handshake corner cases.
module tb_i2s_slave_rx;

    localparam int DW = 24;
    localparam int SS = 2;

    logic          lmmi_clk_i = 1'b0;
    logic          reset_i, conf_en_i, i2s_sck_i, i2s_ws_i, i2s_sd_i, sample_ready_i;
    logic [DW-1:0] left_dat_o, right_dat_o;
    logic          sample_valid_o, overrun_o, short_slot_o, locked_o;

    i2s_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .lmmi_clk_i(lmmi_clk_i), .reset_i(reset_i), .conf_en_i(conf_en_i),
        .i2s_sck_i(i2s_sck_i), .i2s_ws_i(i2s_ws_i), .i2s_sd_i(i2s_sd_i),
        .sample_ready_i(sample_ready_i), .left_dat_o(left_dat_o), .right_dat_o(right_dat_o),
        .sample_valid_o(sample_valid_o), .overrun_o(overrun_o),
        .short_slot_o(short_slot_o), .locked_o(locked_o));

    always #5 lmmi_clk_i = ~lmmi_clk_i;

    typedef struct packed { logic ch; logic sd; } bit_t;
    typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;
    typedef struct {
        logic [31:0] l, r;
        int          n;
        logic [DW-1:0] el, er;
        int          es;
    } vec_t;

    bit_t  bq[$];
    pair_t xq[$];
    int    n_chk = 0, n_fail = 0, ovr_cnt = 0, sh_cnt = 0;
    int    base, ovr0, sh0;

    // Observer: accepted pairs and event pulses.
    always @(negedge lmmi_clk_i) begin
        if (reset_i === 1'b0) begin
            if (sample_valid_o && sample_ready_i) xq.push_back({left_dat_o, right_dat_o});
            if (overrun_o)    ovr_cnt++;
            if (short_slot_o) sh_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the first min(n, DW) slot bits, MSB-first, zero padded.
    function automatic logic [DW-1:0] exp_word(input logic [31:0] v, input int n);
        logic [31:0] m, t;
        m = ~(32'hFFFF_FFFF >> n);
        t = (v & m) >> (32 - DW);
        return t[DW-1:0];
    endfunction

    task automatic push_slot(input logic ch, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) bq.push_back({ch, v[31-i]});
    endtask

    // One SCK period (16 lmmi cycles); WS leads data by one bit.
    task automatic sck_bit(input bit pulse_ready);
        bit_t b;
        logic wsn;
        b   = bq.pop_front();
        wsn = (bq.size() > 0) ? bq[0].ch : b.ch;
        @(posedge lmmi_clk_i); #1;
        i2s_sck_i = 1'b0; i2s_ws_i = wsn; i2s_sd_i = b.sd;
        repeat (8) @(posedge lmmi_clk_i);
        #1 i2s_sck_i = 1'b1;
        if (pulse_ready) begin
            repeat (SS) @(posedge lmmi_clk_i);
            #1 sample_ready_i = 1'b1;
            @(posedge lmmi_clk_i);
            #1 sample_ready_i = 1'b0;
            repeat (6 - SS) @(posedge lmmi_clk_i);
        end else begin
            repeat (7) @(posedge lmmi_clk_i);
        end
    endtask

    task automatic drain(input int hook_at, input int keep);
        int k = 0;
        bit rl;
        while (bq.size() > keep) begin
            rl = (bq[0].ch == 1'b1) && (bq[1].ch == 1'b0);
            if (rl) k++;
            sck_bit(rl && (k == hook_at));
        end
    endtask

    task automatic do_reset();
        @(posedge lmmi_clk_i); #1;
        reset_i = 1'b1; conf_en_i = 1'b0; sample_ready_i = 1'b0;
        i2s_sck_i = 1'b0; i2s_ws_i = 1'b0; i2s_sd_i = 1'b0;
        bq.delete();
        repeat (3) @(posedge lmmi_clk_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic start(input logic rdy);
        do_reset();
        sample_ready_i = rdy;
        base = xq.size(); ovr0 = ovr_cnt; sh0 = sh_cnt;
        conf_en_i = 1'b1;
        push_slot(1'b1, 32'h0, 8);
    endtask

    task automatic chk_pair(input string name, input int idx, input logic [DW-1:0] l, input logic [DW-1:0] r);
        if (xq.size() > base + idx) begin
            chk({name, "_left"},  64'(xq[base+idx].l), 64'(l));
            chk({name, "_right"}, 64'(xq[base+idx].r), 64'(r));
        end
    endtask

    vec_t  tbl[10];
    pair_t rq[$];
    int    nlist[7] = '{8, 16, 20, 23, 24, 25, 32};

    initial begin
        tbl[0] = '{32'hABCDEF00, 32'h12345600, 32, 24'hABCDEF, 24'h123456, 0};
        tbl[1] = '{32'hBEEF0000, 32'h12340000, 16, 24'hBEEF00, 24'h123400, 2};
        tbl[2] = '{32'hA5A5A5FF, 32'h5A5A5A00, 24, 24'hA5A5A5, 24'h5A5A5A, 0};
        tbl[3] = '{32'h81FFFFFF, 32'h7E000000,  8, 24'h810000, 24'h7E0000, 2};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 23, 24'hFFFFFE, 24'hFFFFFE, 2};
        for (int i = 5; i < 10; i++) begin
            tbl[i].l  = $urandom;
            tbl[i].r  = $urandom;
            tbl[i].n  = nlist[$urandom_range(0, 6)];
            tbl[i].el = exp_word(tbl[i].l, tbl[i].n);
            tbl[i].er = exp_word(tbl[i].r, tbl[i].n);
            tbl[i].es = (tbl[i].n < DW) ? 2 : 0;
        end

        // Reset state
        do_reset();
        chk("rst_valid",  64'(sample_valid_o), 64'd0);
        chk("rst_ovr",    64'(overrun_o), 64'd0);
        chk("rst_short",  64'(short_slot_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_left",   64'(left_dat_o), 64'd0);
        chk("rst_right",  64'(right_dat_o), 64'd0);

        // Lock-up: enable mid right slot, then one full frame
        sample_ready_i = 1'b1;
        base = xq.size(); ovr0 = ovr_cnt; sh0 = sh_cnt;
        push_slot(1'b1, 32'h0, 12);
        push_slot(1'b0, 32'hABCDEF00, 32);
        push_slot(1'b1, 32'h12345600, 32);
        push_slot(1'b0, 32'h0, 4);
        repeat (4) sck_bit(1'b0);
        conf_en_i = 1'b1;
        repeat (4) @(posedge lmmi_clk_i);
        #1 chk("lock_sync_locked", 64'(locked_o), 64'd0);
        repeat (7) sck_bit(1'b0);
        chk("lock_pre_edge", 64'(locked_o), 64'd0);
        sck_bit(1'b0);
        chk("lock_post_edge", 64'(locked_o), 64'd1);
        chk("lock_no_partial", 64'(xq.size() - base), 64'd0);
        drain(0, 1);
        repeat (20) @(posedge lmmi_clk_i);
        #1;
        chk("basic_count", 64'(xq.size() - base), 64'd1);
        chk_pair("basic", 0, 24'hABCDEF, 24'h123456);
        chk("basic_ovr",   64'(ovr_cnt - ovr0), 64'd0);
        chk("basic_short", 64'(sh_cnt - sh0), 64'd0);
        chk("basic_valid", 64'(sample_valid_o), 64'd0);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            start(1'b1);
            push_slot(1'b0, tbl[i].l, tbl[i].n);
            push_slot(1'b1, tbl[i].r, tbl[i].n);
            push_slot(1'b0, 32'h0, 4);
            drain(0, 1);
            repeat (20) @(posedge lmmi_clk_i);
            #1;
            chk($sformatf("vec%0d_count", i), 64'(xq.size() - base), 64'd1);
            chk_pair($sformatf("vec%0d", i), 0, tbl[i].el, tbl[i].er);
            chk($sformatf("vec%0d_short", i), 64'(sh_cnt - sh0), 64'(tbl[i].es));
            chk($sformatf("vec%0d_ovr", i), 64'(ovr_cnt - ovr0), 64'd0);
        end

        // Random back-to-back stream
        begin
            int es = 0;
            start(1'b1);
            rq.delete();
            for (int f = 0; f < 4; f++) begin
                logic [31:0] l, r;
                int n;
                l = $urandom; r = $urandom; n = nlist[$urandom_range(0, 6)];
                push_slot(1'b0, l, n);
                push_slot(1'b1, r, n);
                rq.push_back({exp_word(l, n), exp_word(r, n)});
                if (n < DW) es += 2;
            end
            push_slot(1'b0, 32'h0, 4);
            drain(0, 1);
            repeat (20) @(posedge lmmi_clk_i);
            #1;
            chk("rand_count", 64'(xq.size() - base), 64'(rq.size()));
            for (int f = 0; f < rq.size(); f++) chk_pair($sformatf("rand%0d", f), f, rq[f].l, rq[f].r);
            chk("rand_short", 64'(sh_cnt - sh0), 64'(es));
            chk("rand_ovr", 64'(ovr_cnt - ovr0), 64'd0);
        end

        // Overrun with ready held low
        start(1'b0);
        push_slot(1'b0, 32'h00000100, 32); push_slot(1'b1, 32'h00000200, 32);
        push_slot(1'b0, 32'h00000300, 32); push_slot(1'b1, 32'h00000400, 32);
        push_slot(1'b0, 32'h0, 4);
        drain(0, 1);
        repeat (20) @(posedge lmmi_clk_i);
        #1;
        chk("ovr_pulses", 64'(ovr_cnt - ovr0), 64'd1);
        chk("ovr_no_xfer", 64'(xq.size() - base), 64'd0);
        chk("ovr_valid", 64'(sample_valid_o), 64'd1);
        chk("ovr_left",  64'(left_dat_o), 64'h000003);
        chk("ovr_right", 64'(right_dat_o), 64'h000004);
        sample_ready_i = 1'b1;
        @(posedge lmmi_clk_i); #1;
        sample_ready_i = 1'b0;
        chk("ovr_drop_valid", 64'(sample_valid_o), 64'd0);
        chk("ovr_drop_count", 64'(xq.size() - base), 64'd1);
        chk_pair("ovr_drop", 0, 24'h000003, 24'h000004);

        // Ready rises on the very cycle the second pair loads
        start(1'b0);
        push_slot(1'b0, 32'h00000500, 32); push_slot(1'b1, 32'h00000600, 32);
        push_slot(1'b0, 32'h00000700, 32); push_slot(1'b1, 32'h00000800, 32);
        push_slot(1'b0, 32'h0, 4);
        drain(3, 1);
        repeat (20) @(posedge lmmi_clk_i);
        #1;
        chk("sim_count", 64'(xq.size() - base), 64'd1);
        chk_pair("sim_old", 0, 24'h000005, 24'h000006);
        chk("sim_ovr",   64'(ovr_cnt - ovr0), 64'd0);
        chk("sim_valid", 64'(sample_valid_o), 64'd1);
        chk("sim_left",  64'(left_dat_o), 64'h000007);
        chk("sim_right", 64'(right_dat_o), 64'h000008);

        // Disable with a pair held
        start(1'b0);
        push_slot(1'b0, 32'h11111100, 32); push_slot(1'b1, 32'h22222200, 32);
        push_slot(1'b0, 32'h0, 4);
        drain(0, 1);
        repeat (20) @(posedge lmmi_clk_i);
        #1;
        chk("dis_valid_before", 64'(sample_valid_o), 64'd1);
        conf_en_i = 1'b0;
        @(posedge lmmi_clk_i); #1;
        chk("dis_valid",  64'(sample_valid_o), 64'd0);
        chk("dis_locked", 64'(locked_o), 64'd0);
        chk("dis_left",   64'(left_dat_o), 64'h111111);
        chk("dis_right",  64'(right_dat_o), 64'h222222);

        // Reset mid left slot
        start(1'b0);
        push_slot(1'b0, 32'h33333300, 32); push_slot(1'b1, 32'h44444400, 32);
        push_slot(1'b0, 32'h55555555, 32);
        drain(0, 16);
        chk("mid_valid",  64'(sample_valid_o), 64'd1);
        chk("mid_locked", 64'(locked_o), 64'd1);
        @(posedge lmmi_clk_i); #1 reset_i = 1'b1;
        @(posedge lmmi_clk_i); #1;
        chk("mrst_valid",  64'(sample_valid_o), 64'd0);
        chk("mrst_locked", 64'(locked_o), 64'd0);
        chk("mrst_left",   64'(left_dat_o), 64'd0);
        chk("mrst_right",  64'(right_dat_o), 64'd0);
        chk("mrst_ovr",    64'(overrun_o), 64'd0);
        chk("mrst_short",  64'(short_slot_o), 64'd0);
        reset_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
Standalone I2S slave receiver. It accepts SCK, WS and SD from an external I2S master, such as a codec running in master mode or the lscc_i2s_codec TX instance, and resynchronises all three into lmmi_clk_i. It deserialises 24-bit MSB-first left/right words and presents each stereo pair on a single-entry valid/ready output register. It is the receive end for links where the FPGA is not the clock master.

Parameters:
DATA_WIDTH, 24, bits captured per channel (MSB-first); legal range 8..32.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers; minimum 2.

Ports:
lmmi_clk_i  input  1  system clock; all logic on its rising edge.
reset_i  input  1  synchronous, active-high reset.
conf_en_i  input  1  receiver enable; low forces IDLE.
i2s_sck_i  input  1  I2S bit clock; asynchronous to lmmi_clk_i.
i2s_ws_i  input  1  I2S word select; 0 = left, 1 = right.
i2s_sd_i  input  1  I2S serial data.
sample_ready_i  input  1  consumer accepts the pair when high while sample_valid_o is high.
left_dat_o  output  DATA_WIDTH  left word of the held pair.
right_dat_o  output  DATA_WIDTH  right word of the held pair.
sample_valid_o  output  1  held pair is valid.
overrun_o  output  1  one-cycle pulse: an unaccepted pair was overwritten.
short_slot_o  output  1  one-cycle pulse: a closed slot carried fewer than DATA_WIDTH bits.
locked_o  output  1  high in LEFT/RIGHT states.

Behaviour:
- Clocking requirement: f(lmmi_clk_i) >= 8 x f(SCK).
- Synchronisation: each of SCK, WS and SD passes through SYNC_STAGES flops.
  - One further flop on synchronised SCK gives sck_rise = sync & ~prev.
  - WS and SD are sampled from their synchronised outputs in the sck_rise cycle. All three share the same depth, so they stay aligned.
- Reset (reset_i=1 at a clock edge):
  - state = IDLE, ws_last = 0, bit count = 0.
  - Shift register, left_hold, left_dat_o and right_dat_o all cleared to 0.
  - sample_valid_o, overrun_o, short_slot_o, locked_o = 0.
  - Synchroniser flops cleared to 0.
  - Reset mid-frame discards the partial frame.
- States:
  - IDLE: conf_en_i=1 -> SYNC.
  - SYNC: waits for an sck_rise where ws_last=1 and sampled ws=0 (end of a right slot) -> LEFT. No data is output in SYNC.
  - LEFT: on the WS 0->1 transition -> RIGHT.
  - RIGHT: on the WS 1->0 transition -> LEFT, and the pair is published.
  - conf_en_i=0 in any state -> IDLE next cycle, sample_valid_o cleared. Data outputs retain their values.
- ws_last updates to the sampled WS on every sck_rise in SYNC, LEFT and RIGHT.
- Per sck_rise in LEFT/RIGHT (one-bit I2S delay):
  - The bit sampled always belongs to the current slot, including on the rise where WS differs from ws_last.
  - Storing: if cnt < DATA_WIDTH, shreg[DATA_WIDTH-1-cnt] <= sd. cnt saturates at DATA_WIDTH. Excess bits are ignored.
  - If sampled ws != ws_last, the slot closes after this bit is stored.
    - If the final cnt < DATA_WIDTH, short_slot_o pulses and the word keeps its zero-padded LSBs.
    - shreg and cnt clear for the next slot.
- Slot close actions:
  - Left slot close: left_hold <= completed word.
  - Right slot close: left_dat_o <= left_hold, right_dat_o <= completed word, sample_valid_o <= 1.
- Latency: pair outputs update 1 lmmi cycle after the sck_rise detection of the WS 1->0 edge. Pin-to-detection latency is SYNC_STAGES+1 cycles.
- Handshake:
  - Transfer happens in any cycle where valid=1 and ready=1; valid drops the next cycle unless a new pair loads.
  - New pair with valid=1 and ready=0: overwrite, overrun_o=1 for one cycle, valid stays 1.
  - New pair with valid=1 and ready=1 in the same cycle: old pair is transferred, new pair loads, valid stays 1, no overrun.
- WS change while in SYNC does not produce short_slot_o.

Decomposition:
- Package i2s_pkg:
  - state enum rx_state_t {IDLE, SYNC, LEFT, RIGHT}.
  - I2S_LEFT = 1'b0, I2S_RIGHT = 1'b1.
  - Function cnt_width(DATA_WIDTH) = $clog2(DATA_WIDTH+1).
- Sub-module i2s_sync_edge: N-stage synchroniser with an optional rise-detect output. Instantiated for SCK (edge enabled), WS and SD.

Test Plan:
- Common stimulus: SCK period 16 lmmi cycles, 32-bit slots.
- Basic receive: after 1 sync frame, send left=0xABCDEF, right=0x123456 with ready=1 -> exactly one valid pulse with left_dat_o=0xABCDEF, right_dat_o=0x123456, no overrun or short_slot.
- Lock-up: enable mid-right slot -> no valid for the partial frame; locked_o rises after the first WS 1->0; the first pair out is from the next full frame.
- Overrun: ready held 0, send pairs (0x000001, 0x000002) then (0x000003, 0x000004) -> overrun_o pulses once; outputs = 0x000003/0x000004; valid stays 1.
- Short slot: 16-bit slots, left bits 0xBEEF -> left_dat_o=0xBEEF00, short_slot_o pulses twice per frame.
- Simultaneous events: ready rises in the same cycle a new pair loads -> no overrun, new pair held, valid=1.
- Reset/disable: assert reset_i mid-left slot -> all outputs 0 next cycle, state IDLE. Drop conf_en_i with valid=1 -> valid=0 and locked_o=0 next cycle; data retained.
